softshell_mbox: RTL

Wishbone mailbox directly downstream of the softshell user-area Wishbone slave port. It gives the management SoC two 32-bit FIFOs for exchanging words with the softshell cores:
- a down FIFO (mgmt → core);
- an up FIFO (core → mgmt).

It also provides sticky error flags and a level interrupt. It decodes its own 16-byte window and ignores all other addresses, so sibling slaves in softshell_top can share the bus.

---
 rtl/softshell_mbox.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/softshell_mbox.sv
// Wishbone mailbox: a mgmt->core "down" FIFO, a core->mgmt "up" FIFO, sticky
// OVF/UNF flags and a registered level interrupt in a 16-byte window.

module mbox_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Callers gate push/pop with full/empty, so no guarding here.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

module softshell_mbox #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        core_rx_valid,
  output logic [31:0] core_rx_data,
  input  logic        core_rx_ready,
  input  logic        core_tx_valid,
  input  logic [31:0] core_tx_data,
  output logic        core_tx_ready,
  output logic        irq
);
  localparam int NUM_LANES = 4;
  localparam int CW        = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    R_TXDATA = 2'd0,
    R_RXDATA = 2'd1,
    R_STATUS = 2'd2,
    R_IRQEN  = 2'd3
  } reg_e;

  typedef struct packed {
    logic        hit;
    logic        we;
    reg_e        rsel;
    logic [31:0] dat;
  } wb_req_t;

  wb_req_t req;
  logic [NUM_LANES-1:0][7:0] wdata_m;

  logic          dn_push, dn_pop, dn_full, dn_empty;
  logic          up_push, up_pop, up_full, up_empty;
  logic [31:0]   dn_head, up_head;
  logic [CW-1:0] dn_cnt, up_cnt;
  logic          ovf, unf;
  logic [1:0]    irq_en;
  logic [31:0]   status, rdata;
  logic          wr_tx, rd_rx, wr_st, wr_ie;
  logic          unused;

  // The ack term keeps a held strobe from being taken twice.
  assign req.hit  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o &
                    (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign req.we   = wbs_we_i;
  assign req.rsel = reg_e'(wbs_adr_i[3:2]);
  assign req.dat  = wbs_dat_i;
  assign unused   = &{1'b0, wbs_adr_i[1:0]};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wdata_m[i] = wbs_sel_i[i] ? req.dat[i*8 +: 8] : 8'h00;
  end

  assign wr_tx = req.hit &  req.we & (req.rsel == R_TXDATA);
  assign rd_rx = req.hit & ~req.we & (req.rsel == R_RXDATA);
  assign wr_st = req.hit &  req.we & (req.rsel == R_STATUS) & wbs_sel_i[0];
  assign wr_ie = req.hit &  req.we & (req.rsel == R_IRQEN)  & wbs_sel_i[0];

  // Full/empty come from the registered count, so a same-cycle opposite
  // operation never rescues an overflowing push or underflowing pop.
  assign dn_push = wr_tx & ~dn_full;
  assign dn_pop  = ~dn_empty & core_rx_ready;
  assign up_push = core_tx_valid & ~up_full;
  assign up_pop  = rd_rx & ~up_empty;

  mbox_fifo #(.DEPTH(DEPTH), .W(32)) u_dn (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (dn_push),
    .din   (wdata_m),
    .pop   (dn_pop),
    .dout  (dn_head),
    .count (dn_cnt),
    .full  (dn_full),
    .empty (dn_empty)
  );

  mbox_fifo #(.DEPTH(DEPTH), .W(32)) u_up (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (up_push),
    .din   (core_tx_data),
    .pop   (up_pop),
    .dout  (up_head),
    .count (up_cnt),
    .full  (up_full),
    .empty (up_empty)
  );

  assign core_rx_valid = ~dn_empty;
  assign core_rx_data  = dn_head;
  assign core_tx_ready = ~up_full;

  assign status = {8'h00, 8'(up_cnt), 8'(dn_cnt), 2'b00, unf, ovf,
                   up_empty, up_full, dn_empty, dn_full};

  always_comb begin
    rdata = '0;
    case (req.rsel)
      R_RXDATA: rdata = up_empty ? 32'h0 : up_head;
      R_STATUS: rdata = status;
      R_IRQEN:  rdata = {30'h0, irq_en};
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req.hit;
      wbs_dat_o <= (req.hit & ~req.we) ? rdata : 32'h0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ovf    <= 1'b0;
      unf    <= 1'b0;
      irq_en <= 2'b00;
    end else begin
      if (wr_tx & dn_full)              ovf <= 1'b1;
      else if (wr_st & wbs_dat_i[4])    ovf <= 1'b0;
      if (rd_rx & up_empty)             unf <= 1'b1;
      else if (wr_st & wbs_dat_i[5])    unf <= 1'b0;
      if (wr_ie)                        irq_en <= wbs_dat_i[1:0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq <= 1'b0;
    else          irq <= (irq_en[0] & ~up_empty) | (irq_en[1] & dn_empty);
  end
endmodule
